ysyx_25040111_mem_xbar: RTL and testbench
=========================================

YSYX_25040111_MEM_XBAR -- requirements
Module: ysyx_25040111_mem_xbar

Interface
REQ-001 SHALL have parameter N_MST, default 2, number of requesting masters (1..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width (32 or 64).
REQ-004 SHALL have parameter RR_EN, default 1; 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-005 SHALL have parameter TMO, default 255, response-timeout cycles; 0 disables timeout.
REQ-006 SHALL have ports: clock  in  1  sole clock; reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: m_valid in N_MST; m_ready out N_MST; m_addr in N_MST*AW; m_write in N_MST; m_wdata in N_MST*DW; m_wstrb in N_MST*DW/8; m_len in N_MST*8 (beats minus 1).
REQ-008 SHALL have ports: m_rvalid out N_MST; m_rdata out DW (shared); m_rlast out 1; m_wdone out N_MST; m_err out N_MST.
REQ-009 SHALL have ports: s_valid out 1; s_ready in 1; s_addr out AW; s_write out 1; s_wdata out DW; s_wstrb out DW/8; s_len out 8; s_rvalid in 1; s_rdata in DW; s_rlast in 1; s_bvalid in 1; s_err in 1; grant_id out clog2(N_MST) (min 1).

Function
REQ-010 SHALL implement states IDLE, ADDR, RDATA, WRESP.
REQ-011 IDLE: when any m_valid is set, SHALL register the winner into grant_id and enter ADDR next cycle (1-cycle arbitration latency); no m_valid -> stay IDLE.
REQ-012 RR_EN=1: search SHALL start at pointer ptr and wrap N_MST-1 -> 0; RR_EN=0: lowest asserted index wins.
REQ-013 ADDR: s_valid=1, s_addr/s_write/s_wdata/s_wstrb/s_len SHALL equal the granted master's fields; m_ready[grant_id]=s_ready; all other m_ready=0.
REQ-014 On s_valid&s_ready in ADDR, SHALL go to RDATA if write=0, else WRESP; latch len into beat counter.
REQ-015 Masters SHALL hold request fields until handshake; grant SHALL not change in ADDR even if m_valid drops.
REQ-016 RDATA: m_rvalid[grant_id]=s_rvalid, m_rdata=s_rdata; each beat decrements counter; m_rlast=1 on beat where counter==0 or s_rlast=1.
REQ-017 RDATA SHALL return to IDLE after the m_rlast beat; s_rlast before counter==0 SHALL also pulse m_err[grant_id] on that beat.
REQ-018 WRESP: on s_bvalid SHALL pulse m_wdone[grant_id] one cycle and return to IDLE.
REQ-019 s_err=1 with the final read beat or s_bvalid SHALL pulse m_err[grant_id] in the same cycle.
REQ-020 Timeout (TMO>0): idle-cycle counter in RDATA/WRESP, cleared on each s_rvalid/s_bvalid; reaching TMO SHALL pulse m_err[grant_id], end transaction, enter IDLE.
REQ-021 On every transaction end (normal, error, timeout), ptr SHALL become grant_id+1 modulo N_MST.
REQ-022 Non-granted m_rvalid/m_wdone/m_err SHALL be 0; s_rvalid/s_bvalid outside RDATA/WRESP SHALL be ignored.
REQ-023 Back-to-back: a request present on the IDLE cycle after completion SHALL be granted with no extra bubble.
REQ-024 N_MST=1 SHALL function with grant_id constant 0.

Reset
REQ-025 reset SHALL force state IDLE, ptr=0, grant_id=0, counters=0 asynchronously.
REQ-026 During reset all outputs SHALL be 0 (s_valid, m_ready, m_rvalid, m_wdone, m_err, m_rlast, buses).
REQ-027 Reset mid-transaction SHALL abandon it without m_wdone/m_err pulses.

Structure
REQ-028 Package ysyx_25040111_xbar_pkg SHALL hold the state enum and timeout/len width constants.
REQ-029 Round-robin picker SHALL be sub-module ysyx_25040111_rr_pick (combinational: req, ptr -> one-hot/index).

Verification
REQ-030 N_MST=2, both m_valid same cycle from reset -> grant 0 first, then 1; ptr wraps back to 0.
REQ-031 Master 1 read, len=3, slave 4 beats 0xA0..0xA3 -> m_rvalid[1] 4 beats, m_rlast on 0xA3, IDLE next cycle.
REQ-032 Master 0 write addr 0x8000_0000 wstrb 0xF, s_bvalid after 5 cycles -> single m_wdone[0] pulse, m_err[0]=0.
REQ-033 TMO=8, read with no s_rvalid -> m_err pulse 8 cycles after handshake, state IDLE.
REQ-034 s_rlast on beat 2 of len=3 read -> m_rlast and m_err same cycle, transaction ends.
REQ-035 reset asserted in RDATA -> all outputs 0 immediately, no m_err, grant_id=0.

Source files
------------

// File: rtl/ysyx_25040111_xbar_pkg.sv
// rtl/ysyx_25040111_xbar_pkg.sv - shared state type and widths for the memory crossbar
package ysyx_25040111_xbar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_RDATA = 2'd2,
      ST_WRESP = 2'd3
   } xbar_state_e;

   localparam int LEN_W = 8;
   localparam int TMO_W = 16;

   // Index width never drops below one bit so a single master still has a grant_id.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ysyx_25040111_rr_pick.sv
// rtl/ysyx_25040111_rr_pick.sv - combinational rotating-priority picker
module ysyx_25040111_rr_pick
   import ysyx_25040111_xbar_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_any,
   output logic [IW-1:0] o_idx
);

   int w_cand;

   // Search starts at i_ptr and wraps; a zero pointer gives plain lowest-index priority.
   always_comb begin
      o_any  = 1'b0;
      o_idx  = '0;
      w_cand = 0;
      for (int k = 0; k < N; k++) begin
         w_cand = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[w_cand]) begin
            o_any = 1'b1;
            o_idx = IW'(w_cand);
         end
      end
   end

endmodule

// File: rtl/ysyx_25040111_mem_xbar.sv
// rtl/ysyx_25040111_mem_xbar.sv - N-master to single-slave memory crossbar with timeout
module ysyx_25040111_mem_xbar
   import ysyx_25040111_xbar_pkg::*;
#(
   parameter int N_MST = 2,
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int RR_EN = 1,
   parameter int TMO   = 255
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [N_MST-1:0]              m_valid,
   output logic [N_MST-1:0]              m_ready,
   input  logic [N_MST*AW-1:0]           m_addr,
   input  logic [N_MST-1:0]              m_write,
   input  logic [N_MST*DW-1:0]           m_wdata,
   input  logic [N_MST*DW/8-1:0]         m_wstrb,
   input  logic [N_MST*LEN_W-1:0]        m_len,
   output logic [N_MST-1:0]              m_rvalid,
   output logic [DW-1:0]                 m_rdata,
   output logic                          m_rlast,
   output logic [N_MST-1:0]              m_wdone,
   output logic [N_MST-1:0]              m_err,
   output logic                          s_valid,
   input  logic                          s_ready,
   output logic [AW-1:0]                 s_addr,
   output logic                          s_write,
   output logic [DW-1:0]                 s_wdata,
   output logic [DW/8-1:0]               s_wstrb,
   output logic [LEN_W-1:0]              s_len,
   input  logic                          s_rvalid,
   input  logic [DW-1:0]                 s_rdata,
   input  logic                          s_rlast,
   input  logic                          s_bvalid,
   input  logic                          s_err,
   output logic [idx_width(N_MST)-1:0]   grant_id
);

   localparam int IW = idx_width(N_MST);
   localparam int SW = DW / 8;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_MST - 1);

   xbar_state_e      r_state, w_state_nxt;
   logic [IW-1:0]    r_grant, w_grant_nxt;
   logic [IW-1:0]    r_ptr, w_ptr_nxt;
   logic [LEN_W-1:0] r_beats, w_beats_nxt;
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
   logic [IW-1:0]    w_pick_idx, w_pick_ptr, w_ptr_inc;
   logic [N_MST-1:0] w_gsel;
   logic             w_pick_any, w_last, w_early, w_tmo_hit;

   assign w_pick_ptr = (RR_EN != 0) ? r_ptr : '0;
   assign w_ptr_inc  = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
   assign w_gsel     = N_MST'(1) << r_grant;
   assign w_last     = (r_beats == '0) || s_rlast;
   assign w_early    = s_rlast && (r_beats != '0);
   assign w_tmo_hit  = (TMO > 0) && (r_tmo == TMO_W'(TMO - 1));
   assign grant_id   = r_grant;

   ysyx_25040111_rr_pick #(.N(N_MST), .IW(IW)) u_pick (
      .i_req (m_valid),
      .i_ptr (w_pick_ptr),
      .o_any (w_pick_any),
      .o_idx (w_pick_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      w_beats_nxt = r_beats;
      w_tmo_nxt   = r_tmo;
      m_ready     = '0;
      m_rvalid    = '0;
      m_rdata     = '0;
      m_rlast     = 1'b0;
      m_wdone     = '0;
      m_err       = '0;
      s_valid     = 1'b0;
      s_addr      = '0;
      s_write     = 1'b0;
      s_wdata     = '0;
      s_wstrb     = '0;
      s_len       = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_grant_nxt = w_pick_idx;
               w_state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            s_valid = 1'b1;
            s_addr  = m_addr[r_grant*AW +: AW];
            s_write = m_write[r_grant];
            s_wdata = m_wdata[r_grant*DW +: DW];
            s_wstrb = m_wstrb[r_grant*SW +: SW];
            s_len   = m_len[r_grant*LEN_W +: LEN_W];
            m_ready = s_ready ? w_gsel : '0;
            if (s_ready) begin
               w_beats_nxt = m_len[r_grant*LEN_W +: LEN_W];
               w_tmo_nxt   = '0;
               w_state_nxt = m_write[r_grant] ? ST_WRESP : ST_RDATA;
            end
         end
         ST_RDATA: begin
            m_rdata = s_rdata;
            if (s_rvalid) begin
               m_rvalid    = w_gsel;
               m_rlast     = w_last;
               w_beats_nxt = r_beats - 1'b1;
               w_tmo_nxt   = '0;
               if (w_last) begin
                  m_err       = (w_early || s_err) ? w_gsel : '0;
                  w_state_nxt = ST_IDLE;
                  w_ptr_nxt   = w_ptr_inc;
               end
            end else if (w_tmo_hit) begin
               m_err       = w_gsel;
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_ptr_inc;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         ST_WRESP: begin
            if (s_bvalid) begin
               m_wdone     = w_gsel;
               m_err       = s_err ? w_gsel : '0;
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_ptr_inc;
            end else if (w_tmo_hit) begin
               m_err       = w_gsel;
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_ptr_inc;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
         r_beats <= '0;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
         r_beats <= w_beats_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

endmodule

// File: tb/tb_ysyx_25040111_mem_xbar.sv
// tb/tb_ysyx_25040111_mem_xbar.sv - self-checking bench for the memory crossbar
module tb_ysyx_25040111_mem_xbar;

   localparam int TMO_P = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  mv;
   logic [31:0] ma [2];
   logic [31:0] mwd [2];
   logic [3:0]  ms [2];
   logic [7:0]  ml [2];
   logic [1:0]  mw;
   logic        s_ready, s_rvalid, s_rlast, s_bvalid, s_err;
   logic [31:0] s_rdata;

   logic [1:0]  m_ready, m_rvalid, m_wdone, m_err;
   logic [31:0] m_rdata, s_addr, s_wdata;
   logic        m_rlast, s_valid, s_write;
   logic [3:0]  s_wstrb;
   logic [7:0]  s_len;
   logic [0:0]  grant_id;

   logic [1:0]  e_ready, e_rvalid, e_wdone, e_err;
   logic        e_rlast, e_svalid, e_swrite, e_gid;
   logic [31:0] e_saddr, e_swdata, e_rdata;
   logic [3:0]  e_sstrb;
   logic [7:0]  e_slen;

   int total = 0, bad = 0, cyc = 0;
   int gid = 0, ptr = 0, cur = 0;
   bit in_rst;
   int gq[$];
   int hs_cyc, err_cyc, rv1_cnt, wd0_cnt, err0_cnt;
   logic [31:0] last_rdata;

   always #5 clock = ~clock;

   ysyx_25040111_mem_xbar #(.N_MST(2), .AW(32), .DW(32), .RR_EN(1), .TMO(TMO_P)) dut (
      .clock(clock), .reset(reset),
      .m_valid(mv), .m_ready(m_ready), .m_addr({ma[1], ma[0]}), .m_write(mw),
      .m_wdata({mwd[1], mwd[0]}), .m_wstrb({ms[1], ms[0]}), .m_len({ml[1], ml[0]}),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_wdone(m_wdone), .m_err(m_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_write(s_write),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_len(s_len), .s_rvalid(s_rvalid),
      .s_rdata(s_rdata), .s_rlast(s_rlast), .s_bvalid(s_bvalid), .s_err(s_err),
      .grant_id(grant_id)
   );

   function automatic int pick(input logic [1:0] req, input int p);
      int c;
      for (int k = 0; k < 2; k++) begin
         c = (p + k) % 2;
         if (req[c]) return c;
      end
      return 0;
   endfunction

   task automatic clr_exp();
      e_ready = '0; e_rvalid = '0; e_wdone = '0; e_err = '0; e_rlast = 1'b0;
      e_svalid = 1'b0; e_swrite = 1'b0; e_saddr = '0; e_swdata = '0; e_rdata = '0;
      e_sstrb = '0; e_slen = '0; e_gid = 1'(gid);
   endtask

   task automatic cmp_cycle();
      logic [10:0] ac, ec;
      logic [76:0] ab, eb;
      ac = {m_ready, m_rvalid, m_rlast, m_wdone, m_err, s_valid, grant_id};
      ec = {e_ready, e_rvalid, e_rlast, e_wdone, e_err, e_svalid, e_gid};
      total++;
      if (ac !== ec) begin
         bad++;
         $display("FAIL ctrl cyc=%0d act=%h req=%h", cyc, ac, ec);
      end
      if (e_svalid || in_rst) begin
         ab = {s_addr, s_write, s_wdata, s_wstrb, s_len};
         eb = {e_saddr, e_swrite, e_swdata, e_sstrb, e_slen};
         total++;
         if (ab !== eb) begin
            bad++;
            $display("FAIL sbus cyc=%0d act=%h req=%h", cyc, ab, eb);
         end
      end
      if (e_rvalid != 2'b00 || in_rst) begin
         total++;
         if (m_rdata !== e_rdata) begin
            bad++;
            $display("FAIL rdata cyc=%0d act=%h req=%h", cyc, m_rdata, e_rdata);
         end
      end
      if (s_valid && s_ready) begin gq.push_back(int'(grant_id)); hs_cyc = cyc; end
      if (m_err != 2'b00) err_cyc = cyc;
      if (m_rvalid[1]) rv1_cnt++;
      if (m_rlast) last_rdata = m_rdata;
      if (m_wdone[0]) wd0_cnt++;
      if (m_err[0]) err0_cnt++;
   endtask

   task automatic step();
      @(negedge clock);
      cmp_cycle();
      @(posedge clock);
      #1;
      cyc++;
      s_ready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_err = 1'b0; s_bvalid = 1'b0; s_rdata = '0;
      clr_exp();
   endtask

   task automatic pin(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s act=%0d req=%0d", nm, act, req);
      end
   endtask

   task automatic setm(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, input logic [7:0] len);
      mw[i] = wr; ma[i] = a; mwd[i] = d; ms[i] = st; ml[i] = len; mv[i] = 1'b1;
   endtask

   task automatic arb();
      int g;
      g = pick(mv, ptr);
      step();
      gid = g; cur = g; e_gid = 1'(g);
   endtask

   task automatic addr_phase(input int dly);
      for (int d = 0; d <= dly; d++) begin
         s_ready  = (d == dly);
         e_svalid = 1'b1; e_saddr = ma[cur]; e_swrite = mw[cur]; e_swdata = mwd[cur];
         e_sstrb  = ms[cur]; e_slen = ml[cur];
         e_ready  = s_ready ? (2'b01 << cur) : 2'b00;
         step();
      end
      mv[cur] = 1'b0;
   endtask

   task automatic read_phase(input logic [31:0] base, input int gap, input int rlast_at, input bit err_fin);
      int b;
      bit fin;
      b = 0; fin = 1'b0;
      while (!fin) begin
         for (int i = 0; i < gap; i++) step();
         s_rvalid = 1'b1; s_rdata = base + 32'(b); s_rlast = (b == rlast_at);
         fin      = (b == int'(ml[cur])) || s_rlast;
         s_err    = fin && err_fin;
         e_rvalid = 2'b01 << cur; e_rdata = s_rdata; e_rlast = fin;
         if (fin && (err_fin || b < int'(ml[cur]))) e_err = 2'b01 << cur;
         if (fin) ptr = (cur + 1) % 2;
         step();
         b++;
      end
   endtask

   task automatic write_phase(input int dly, input bit err);
      for (int i = 0; i < dly; i++) step();
      s_bvalid = 1'b1; s_err = err;
      e_wdone  = 2'b01 << cur;
      e_err    = err ? (2'b01 << cur) : 2'b00;
      ptr = (cur + 1) % 2;
      step();
   endtask

   task automatic tmo_phase();
      for (int i = 1; i < TMO_P; i++) step();
      e_err = 2'b01 << cur;
      ptr = (cur + 1) % 2;
      step();
   endtask

   task automatic stray_idle();
      s_rvalid = 1'b1; s_bvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'hFFFF_FFFF;
      step();
   endtask

   initial begin
      reset = 1'b1; in_rst = 1'b1; mv = '0; mw = '0;
      for (int i = 0; i < 2; i++) begin ma[i] = '0; mwd[i] = '0; ms[i] = '0; ml[i] = '0; end
      s_ready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_bvalid = 1'b0; s_err = 1'b0; s_rdata = '0;
      hs_cyc = 0; err_cyc = 0; rv1_cnt = 0; wd0_cnt = 0; err0_cnt = 0; last_rdata = '0;
      clr_exp();
      #1;
      step();
      step();
      reset = 1'b0; in_rst = 1'b0;

      // both masters from reset: 0 then 1
      setm(0, 0, 32'h0000_0100, 32'h0, 4'h0, 8'd0);
      setm(1, 0, 32'h0000_0200, 32'h0, 4'h0, 8'd0);
      arb(); addr_phase(0); read_phase(32'h11, 0, -1, 0);
      arb(); addr_phase(0); read_phase(32'h22, 0, -1, 0);
      pin("rr_count", gq.size(), 2);
      if (gq.size() >= 2) begin
         pin("rr_first", gq[0], 0);
         pin("rr_second", gq[1], 1);
      end

      // master 1 burst read, four beats with gaps
      rv1_cnt = 0;
      setm(1, 0, 32'h0000_3000, 32'h0, 4'h0, 8'd3);
      arb(); addr_phase(1); read_phase(32'hA0, 1, -1, 0);
      stray_idle();
      pin("rd_beats", rv1_cnt, 4);
      pin("rd_lastdata", int'(last_rdata), 32'hA3);

      // master 0 write with delayed response
      wd0_cnt = 0; err0_cnt = 0;
      setm(0, 1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 8'd0);
      arb(); addr_phase(2); write_phase(4, 0);
      step();
      pin("wr_wdone", wd0_cnt, 1);
      pin("wr_noerr", err0_cnt, 0);

      // early s_rlast on beat 2 of a 4-beat read
      err0_cnt = 0;
      setm(0, 0, 32'h0000_4000, 32'h0, 4'h0, 8'd3);
      arb(); addr_phase(0); read_phase(32'hB0, 0, 2, 0);
      pin("early_err", err0_cnt, 1);
      pin("early_data", int'(last_rdata), 32'hB2);

      // slave error on write response and on final read beat
      setm(1, 1, 32'h0000_5000, 32'h1234_5678, 4'h3, 8'd0);
      arb(); addr_phase(0); write_phase(1, 1);
      setm(0, 0, 32'h0000_6000, 32'h0, 4'h0, 8'd1);
      arb(); addr_phase(0); read_phase(32'hC0, 0, -1, 1);

      // timeout on a silent read
      setm(1, 0, 32'h0000_7000, 32'h0, 4'h0, 8'd2);
      arb(); addr_phase(0); tmo_phase();
      stray_idle();
      pin("tmo_cycles", err_cyc - hs_cyc, TMO_P);

      // reset in the middle of a read granted to master 1
      setm(0, 1, 32'h0000_0010, 32'h0000_0001, 4'h1, 8'd0);
      arb(); addr_phase(0); write_phase(0, 0);
      setm(1, 0, 32'h0000_9000, 32'h0, 4'h0, 8'd3);
      arb(); addr_phase(0);
      s_rvalid = 1'b1; s_rdata = 32'hD0;
      e_rvalid = 2'b10; e_rdata = 32'hD0;
      step();
      reset = 1'b1; in_rst = 1'b1; gid = 0; ptr = 0;
      clr_exp();
      s_rvalid = 1'b1; s_rlast = 1'b1; s_err = 1'b1; s_rdata = 32'hFF;
      step();
      reset = 1'b0; in_rst = 1'b0;
      setm(0, 0, 32'h0000_A000, 32'h0, 4'h0, 8'd0);
      setm(1, 0, 32'h0000_B000, 32'h0, 4'h0, 8'd0);
      arb(); addr_phase(0); read_phase(32'hE0, 0, -1, 0);
      arb(); addr_phase(0); read_phase(32'hF0, 0, -1, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
